// File: rtl/cpu_mips.sv
// ============================================================================
// Module      : cpu_mips
// Description : Single-cycle 32-bit MIPS subset core fetching from 128-bit
//               lines. Optional macro CPUMIPS_JUMP_EN enables the j instruction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_mips #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [127:0] ii_miss_data,
    input  logic [127:0] id_miss_data,
    output logic [31:0]  oi_addr,
    output logic [31:0]  od_addr,
    output logic [31:0]  od_write_data,
    output logic         od_SIG_write
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [2:0] c_ALU_ADD = 3'd0;
    localparam logic [2:0] c_ALU_SUB = 3'd1;
    localparam logic [2:0] c_ALU_AND = 3'd2;
    localparam logic [2:0] c_ALU_OR  = 3'd3;
    localparam logic [2:0] c_ALU_SLT = 3'd4;

    logic [31:0] r_pc;
    logic [31:0] r_regs [0:31];

    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_simm;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_alu_b;
    logic [2:0]  w_alu_op;
    logic [31:0] w_alu_res;
    logic        w_we;
    logic [4:0]  w_wa;
    logic        w_mem_rd;
    logic        w_store;
    logic        w_branch;
    logic        w_jump;
    logic [31:0] w_load_data;
    logic [31:0] w_wb_data;
    logic [31:0] w_pc4;
    logic [31:0] w_pc_next;
    logic        w_unused_shamt;

    // PC bits [3:2] pick the word, so the program wraps over the same line.
    assign w_instr  = ii_miss_data[{r_pc[3:2], 5'b0} +: 32];
    assign w_op     = w_instr[31:26];
    assign w_rs     = w_instr[25:21];
    assign w_rt     = w_instr[20:16];
    assign w_rd     = w_instr[15:11];
    assign w_funct  = w_instr[5:0];
    assign w_simm   = {{16{w_instr[15]}}, w_instr[15:0]};
    assign w_unused_shamt = ^w_instr[10:6];

    assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];

    always_comb begin
        w_alu_b  = w_rt_val;
        w_alu_op = c_ALU_ADD;
        w_we     = 1'b0;
        w_wa     = w_rd;
        w_mem_rd = 1'b0;
        w_store  = 1'b0;
        w_branch = 1'b0;
        w_jump   = 1'b0;
        case (w_op)
            c_OP_RTYPE: begin
                case (w_funct)
                    6'h20: begin w_alu_op = c_ALU_ADD; w_we = 1'b1; end
                    6'h22: begin w_alu_op = c_ALU_SUB; w_we = 1'b1; end
                    6'h24: begin w_alu_op = c_ALU_AND; w_we = 1'b1; end
                    6'h25: begin w_alu_op = c_ALU_OR;  w_we = 1'b1; end
                    6'h2A: begin w_alu_op = c_ALU_SLT; w_we = 1'b1; end
                    default: w_we = 1'b0;
                endcase
            end
            c_OP_ADDI: begin
                w_alu_b = w_simm;
                w_we    = 1'b1;
                w_wa    = w_rt;
            end
            c_OP_LW: begin
                w_alu_b  = w_simm;
                w_we     = 1'b1;
                w_wa     = w_rt;
                w_mem_rd = 1'b1;
            end
            c_OP_SW: begin
                w_alu_b = w_simm;
                w_store = 1'b1;
            end
            c_OP_BEQ: begin
                w_alu_op = c_ALU_SUB;
                w_branch = 1'b1;
            end
`ifdef CPUMIPS_JUMP_EN
            c_OP_J: w_jump = 1'b1;
`else
            c_OP_J: w_jump = 1'b0;
`endif
            default: w_we = 1'b0;
        endcase
    end

    always_comb begin
        w_alu_res = 32'd0;
        case (w_alu_op)
            c_ALU_ADD: w_alu_res = w_rs_val + w_alu_b;
            c_ALU_SUB: w_alu_res = w_rs_val - w_alu_b;
            c_ALU_AND: w_alu_res = w_rs_val & w_alu_b;
            c_ALU_OR:  w_alu_res = w_rs_val | w_alu_b;
            c_ALU_SLT: w_alu_res = {31'd0, $signed(w_rs_val) < $signed(w_alu_b)};
            default:   w_alu_res = 32'd0;
        endcase
    end

    assign w_load_data = id_miss_data[{w_alu_res[3:2], 5'b0} +: 32];
    assign w_wb_data   = w_mem_rd ? w_load_data : w_alu_res;

    assign w_pc4 = r_pc + 32'd4;

    always_comb begin
        w_pc_next = w_pc4;
        if (w_jump)
            w_pc_next = {w_pc4[31:28], w_instr[25:0], 2'b00};
        else if (w_branch && (w_rs_val == w_rt_val))
            w_pc_next = w_pc4 + {w_simm[29:0], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_pc <= PC_RESET;
            for (int i = 0; i < 32; i++)
                r_regs[i] <= 32'(i);
        end else begin
            r_pc <= w_pc_next;
            if (w_we && (w_wa != 5'd0))
                r_regs[w_wa] <= w_wb_data;
        end
    end

    assign oi_addr       = r_pc;
    assign od_addr       = w_alu_res;
    assign od_write_data = w_rt_val;
    // Store strobe is suppressed while reset is held so memory never sees a write.
    assign od_SIG_write  = w_store & ~rstn;

endmodule

`default_nettype wire

// File: tb/tb_cpu_mips.sv
// ============================================================================
// Module      : tb_cpu_mips
// Description : Scoreboard testbench for cpu_mips (honours CPUMIPS_JUMP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_mips;

    localparam logic [31:0] c_NOP = 32'h0000_0020;
    localparam logic [3:0]  c_ALL = 4'b1111;

    logic         clk;
    logic         rstn;
    logic [127:0] ii_miss_data;
    logic [127:0] id_miss_data;
    logic [31:0]  oi_addr;
    logic [31:0]  od_addr;
    logic [31:0]  od_write_data;
    logic         od_SIG_write;

    typedef struct {
        string       tag;
        logic [31:0] oi;
        logic [31:0] dad;
        logic [31:0] dwd;
        logic        wr;
        logic [3:0]  care;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    cpu_mips #(.PC_RESET(32'h0000_0000)) u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .ii_miss_data  (ii_miss_data),
        .id_miss_data  (id_miss_data),
        .oi_addr       (oi_addr),
        .od_addr       (od_addr),
        .od_write_data (od_write_data),
        .od_SIG_write  (od_SIG_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drive one instruction cycle and score the combinational outputs before its edge.
    task automatic step(input logic rst, input logic [127:0] iline, input logic [127:0] dline,
                        input string tag, input logic [31:0] e_oi, input logic [31:0] e_dad,
                        input logic [31:0] e_dwd, input logic e_wr, input logic [3:0] care);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rstn         = rst;
        ii_miss_data = iline;
        id_miss_data = dline;
        e.tag = tag; e.oi = e_oi; e.dad = e_dad; e.dwd = e_dwd; e.wr = e_wr; e.care = care;
        sb_q.push_back(e);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s: scoreboard empty got 0 expected 1", tag);
        end else begin
            g = sb_q.pop_front();
            if (g.care[0]) check_vec({g.tag, ".oi_addr"}, oi_addr, g.oi);
            if (g.care[1]) check_vec({g.tag, ".od_addr"}, od_addr, g.dad);
            if (g.care[2]) check_vec({g.tag, ".od_write_data"}, od_write_data, g.dwd);
            if (g.care[3]) check_vec({g.tag, ".od_SIG_write"}, {31'd0, od_SIG_write}, {31'd0, g.wr});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        logic [127:0] l_arith;
        logic [127:0] l_slt;
        logic [127:0] l_logic;
        logic [127:0] l_st;
        logic [127:0] l_ld;
        logic [127:0] l_dmem;
        logic [127:0] l_br;
        logic [127:0] l_rst;
        logic [127:0] l_j;
        logic [31:0]  j_next;

        n_vec = 0;
        n_err = 0;
        rstn = 1'b1;
        ii_miss_data = {4{c_NOP}};
        id_miss_data = '0;

        l_arith = {32'h0021_0820, c_NOP, c_NOP, 32'h0043_0820};
        l_slt   = {32'h0080_082A, 32'h0005_2022, 32'h0042_082A, 32'h0043_082A};
        l_logic = {32'h0022_0822, 32'h2041_FFFD, 32'h00A6_0825, 32'h00A6_0824};
        l_st    = {c_NOP, c_NOP, c_NOP, 32'hAC62_0008};
        l_ld    = {c_NOP, c_NOP, 32'h0020_0820, 32'h8C61_0008};
        l_dmem  = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
        l_br    = {32'h1022_0002, c_NOP, c_NOP, 32'h1000_0002};
        l_rst   = {c_NOP, 32'h0000_0820, 32'h0043_0020, 32'hAC01_0000};
        l_j     = {c_NOP, c_NOP, c_NOP, 32'h0800_0003};
`ifdef CPUMIPS_JUMP_EN
        j_next = 32'd12;
`else
        j_next = 32'd4;
`endif

        // Arithmetic loop over one line
        do_reset();
        step(0, l_arith, '0, "arith0", 32'd0,  32'd5,  32'd3, 0, c_ALL);
        step(0, l_arith, '0, "arith1", 32'd4,  32'd0,  32'd0, 0, c_ALL);
        step(0, l_arith, '0, "arith2", 32'd8,  32'd0,  32'd0, 0, c_ALL);
        step(0, l_arith, '0, "arith3", 32'd12, 32'd10, 32'd5, 0, c_ALL);
        step(0, l_arith, '0, "arith4", 32'd16, 32'd5,  32'd3, 0, c_ALL);

        // slt, including a signed negative operand
        do_reset();
        step(0, l_slt, '0, "slt_lt",  32'd0,  32'd1,          32'd3, 0, c_ALL);
        step(0, l_slt, '0, "slt_eq",  32'd4,  32'd0,          32'd2, 0, c_ALL);
        step(0, l_slt, '0, "sub_neg", 32'd8,  32'hFFFF_FFFB,  32'd5, 0, c_ALL);
        step(0, l_slt, '0, "slt_neg", 32'd12, 32'd1,          32'd0, 0, c_ALL);

        // and / or / addi negative immediate / sub wrap
        do_reset();
        step(0, l_logic, '0, "and",  32'd0,  32'd4,          32'd6, 0, c_ALL);
        step(0, l_logic, '0, "or",   32'd4,  32'd7,          32'd6, 0, c_ALL);
        step(0, l_logic, '0, "addi", 32'd8,  32'hFFFF_FFFF,  32'd7, 0, c_ALL);
        step(0, l_logic, '0, "sub",  32'd12, 32'hFFFF_FFFD,  32'd2, 0, c_ALL);

        // Store
        do_reset();
        step(0, l_st, '0, "sw",     32'd0, 32'd11, 32'd2, 1, c_ALL);
        step(0, l_st, '0, "sw_nop", 32'd4, 32'd0,  32'd0, 0, c_ALL);

        // Load then read back through the ALU
        do_reset();
        step(0, l_ld, l_dmem, "lw",      32'd0, 32'd11,        32'd1, 0, c_ALL);
        step(0, l_ld, l_dmem, "lw_read", 32'd4, 32'hDEAD_BEEF, 32'd0, 0, c_ALL);

        // Branch taken / not taken / taken from a wrapped PC
        do_reset();
        step(0, l_br, '0, "beq_t",  32'd0,  32'd0, 32'd0, 0, 4'b1101);
        step(0, l_br, '0, "beq_nt", 32'd12, 32'd0, 32'd2, 0, 4'b1101);
        step(0, l_br, '0, "beq_t2", 32'd16, 32'd0, 32'd0, 0, 4'b1101);
        step(0, l_br, '0, "beq_dst",32'd28, 32'd0, 32'd0, 0, 4'b0001);

        // Jump (nop unless the feature is built in)
        do_reset();
        step(0, l_j, '0, "j",      32'd0,  32'd0, 32'd0, 0, 4'b1001);
        step(0, l_j, '0, "j_next", j_next, 32'd0, 32'd0, 0, 4'b0001);

        // Reset asserted mid-run, then a write to $0
        do_reset();
        step(0, l_arith, '0, "mr0",      32'd0,  32'd5,  32'd3, 0, c_ALL);
        step(0, l_arith, '0, "mr1",      32'd4,  32'd0,  32'd0, 0, c_ALL);
        step(0, l_arith, '0, "mr2",      32'd8,  32'd0,  32'd0, 0, c_ALL);
        step(1, l_arith, '0, "mr3_rst",  32'd12, 32'd10, 32'd5, 0, c_ALL);
        step(1, l_rst,   '0, "rst_hold", 32'd0,  32'd0,  32'd1, 0, c_ALL);
        step(0, l_rst,   '0, "rst_sw",   32'd0,  32'd0,  32'd1, 1, c_ALL);
        step(0, l_rst,   '0, "wr_r0",    32'd4,  32'd5,  32'd3, 0, c_ALL);
        step(0, l_rst,   '0, "rd_r0",    32'd8,  32'd0,  32'd0, 0, c_ALL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
